// File: rtl/cond_unit.sv
// Execute-stage condition unit: holds the NZCV flags, evaluates the instruction
// condition against them, gates the write controls and registers the E/M stage.
module cond_unit #(
  parameter logic [3:0]  FLAG_RST = 4'b0000,
  parameter int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [3:0]    CondE,
  input  logic [1:0]    FlagWriteE,
  input  logic [3:0]    ALUFlags,
  input  logic [DW-1:0] ALUResultE,
  input  logic          RegWriteE,
  input  logic          MemWriteE,
  input  logic          PCSrcE,
  input  logic          StallM,
  input  logic          FlushE,
  output logic          CondExE,
  output logic          BranchTakenE,
  output logic [3:0]    Flags,
  output logic          RegWriteM,
  output logic          MemWriteM,
  output logic          PCSrcM,
  output logic [DW-1:0] ALUResultM
);

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  logic [3:0]    flags_q, flags_d;
  logic          regwrite_q, memwrite_q, pcsrc_q;
  logic [DW-1:0] aluresult_q;
  logic          cond_ex;
  logic          flag_n, flag_z, flag_c, flag_v;
  logic          flag_en;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  // Condition decode from the registered flags only (no bypass from ALUFlags)
  always_comb begin
    cond_ex = 1'b0;
    case (cond_e'(CondE))
      COND_EQ: cond_ex = flag_z;
      COND_NE: cond_ex = ~flag_z;
      COND_CS: cond_ex = flag_c;
      COND_CC: cond_ex = ~flag_c;
      COND_MI: cond_ex = flag_n;
      COND_PL: cond_ex = ~flag_n;
      COND_VS: cond_ex = flag_v;
      COND_VC: cond_ex = ~flag_v;
      COND_HI: cond_ex = flag_c & ~flag_z;
      COND_LS: cond_ex = ~flag_c | flag_z;
      COND_GE: cond_ex = (flag_n == flag_v);
      COND_LT: cond_ex = (flag_n != flag_v);
      COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex = flag_z | (flag_n != flag_v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

  assign flag_en = ~StallM & ~FlushE & cond_ex;

  // Next flags: NZ and CV halves update independently, unselected bits hold
  always_comb begin
    flags_d = flags_q;
    if (flag_en) begin
      if (FlagWriteE[1]) flags_d[3:2] = ALUFlags[3:2];
      if (FlagWriteE[0]) flags_d[1:0] = ALUFlags[1:0];
    end
  end

  // Flags register
  always_ff @(posedge clk) begin
    if (reset) flags_q <= FLAG_RST;
    else       flags_q <= flags_d;
  end

  // E/M pipeline register: stall holds everything, flush clears only controls
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      pcsrc_q     <= 1'b0;
      aluresult_q <= '0;
    end else if (!StallM) begin
      if (FlushE) begin
        regwrite_q <= 1'b0;
        memwrite_q <= 1'b0;
        pcsrc_q    <= 1'b0;
      end else begin
        regwrite_q <= RegWriteE & cond_ex;
        memwrite_q <= MemWriteE & cond_ex;
        pcsrc_q    <= PCSrcE & cond_ex;
      end
      aluresult_q <= ALUResultE;
    end
  end

  assign CondExE      = cond_ex;
  assign BranchTakenE = PCSrcE & cond_ex & ~FlushE;
  assign Flags        = flags_q;
  assign RegWriteM    = regwrite_q;
  assign MemWriteM    = memwrite_q;
  assign PCSrcM       = pcsrc_q;
  assign ALUResultM   = aluresult_q;

endmodule
